// File: rtl/render_pkg.sv
// Shared types and header-field layout for the display-list walker.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        GET_HDR,
        RD_DATA,
        GET_DATA,
        DRAW,
        DONE
    } state_t;

    localparam int TYPE_MSB  = 7;
    localparam int TYPE_LSB  = 2;
    localparam int NVERT_MSB = 1;
    localparam int NVERT_LSB = 0;

    localparam logic [1:0] NVERT_END = 2'd0;

    function automatic logic [1:0] hdr_nvert(input logic [7:0] hdr);
        return hdr[NVERT_MSB:NVERT_LSB];
    endfunction

endpackage

// File: rtl/render_cmd_sequencer_if.sv
// Display-list memory port and render-unit port of the command sequencer.
interface render_cmd_sequencer_if;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       ru_status;
    logic       ru_reading;
    logic [7:0] ru_byte;
    logic       ru_finish_write;

    modport master (
        output mem_rd, mem_addr, ru_status, ru_reading, ru_byte,
        input  mem_data, ru_finish_write
    );

    modport slave (
        input  mem_rd, mem_addr, ru_status, ru_reading, ru_byte,
        output mem_data, ru_finish_write
    );
endinterface

// File: rtl/render_cmd_sequencer.sv
// Walks a byte display list, forwards object bytes to the render unit and
// triggers one draw per object, with an inline draw watchdog.
module render_cmd_sequencer
    import render_pkg::*;
#(
    parameter int WDOG_W = 16
) (
    input  logic                          ACLK,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    list_base,
    input  logic [7:0]                    list_len,
    render_cmd_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [7:0]                    obj_count
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = ~(WDOG_W'(1));

    state_t            state_reg;
    logic [7:0]        ptr_reg;
    logic [8:0]        remaining_reg;
    logic [2:0]        byte_cnt_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic              mem_rd_reg;
    logic [7:0]        mem_addr_reg;
    logic              ru_status_reg;
    logic              ru_reading_reg;
    logic [7:0]        ru_byte_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [7:0]        obj_count_reg;
    logic [1:0]        nvert;

    assign nvert = hdr_nvert(bus.mem_data);

    always_ff @(posedge ACLK) begin
        mem_rd_reg <= 1'b0;
        done_reg   <= 1'b0;
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= 8'd0;
            remaining_reg  <= 9'd0;
            byte_cnt_reg   <= 3'd0;
            wdog_reg       <= '0;
            mem_addr_reg   <= 8'd0;
            ru_status_reg  <= 1'b0;
            ru_reading_reg <= 1'b0;
            ru_byte_reg    <= 8'd0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            obj_count_reg  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    state_reg     <= RD_HDR;
                    mem_rd_reg    <= 1'b1;
                    mem_addr_reg  <= list_base;
                    ptr_reg       <= list_base + 8'd1;
                    // The first read is issued here, so remaining already counts it.
                    remaining_reg <= (list_len == 8'd0) ? 9'd255 : {1'b0, list_len} - 9'd1;
                    busy_reg      <= 1'b1;
                    err_reg       <= 1'b0;
                    obj_count_reg <= 8'd0;
                end
                RD_HDR, RD_DATA: begin
                    state_reg      <= (state_reg == RD_HDR) ? GET_HDR : GET_DATA;
                    ru_status_reg  <= 1'b1;
                    ru_reading_reg <= 1'b1;
                end
                GET_HDR: begin
                    ru_byte_reg    <= bus.mem_data;
                    ru_status_reg  <= 1'b0;
                    ru_reading_reg <= 1'b0;
                    byte_cnt_reg   <= {nvert, 1'b0};
                    if (nvert == NVERT_END || remaining_reg == 9'd0) begin
                        err_reg   <= (nvert != NVERT_END);
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg     <= RD_DATA;
                        mem_rd_reg    <= 1'b1;
                        mem_addr_reg  <= ptr_reg;
                        ptr_reg       <= ptr_reg + 8'd1;
                        remaining_reg <= remaining_reg - 9'd1;
                    end
                end
                GET_DATA: begin
                    ru_byte_reg    <= bus.mem_data;
                    ru_reading_reg <= 1'b0;
                    byte_cnt_reg   <= byte_cnt_reg - 3'd1;
                    if (byte_cnt_reg == 3'd1) begin
                        state_reg <= DRAW;
                        wdog_reg  <= '0;
                    end else if (remaining_reg == 9'd0) begin
                        ru_status_reg <= 1'b0;
                        err_reg       <= 1'b1;
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        ru_status_reg <= 1'b0;
                        state_reg     <= RD_DATA;
                        mem_rd_reg    <= 1'b1;
                        mem_addr_reg  <= ptr_reg;
                        ptr_reg       <= ptr_reg + 8'd1;
                        remaining_reg <= remaining_reg - 9'd1;
                    end
                end
                DRAW: begin
                    if (bus.ru_finish_write) begin
                        ru_status_reg <= 1'b0;
                        if (obj_count_reg != 8'hFF)
                            obj_count_reg <= obj_count_reg + 8'd1;
                        if (remaining_reg == 9'd0) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= RD_HDR;
                            mem_rd_reg    <= 1'b1;
                            mem_addr_reg  <= ptr_reg;
                            ptr_reg       <= ptr_reg + 8'd1;
                            remaining_reg <= remaining_reg - 9'd1;
                        end
                    end else if (wdog_reg == WDOG_LAST) begin
                        // Render unit never answered: abandon the list.
                        ru_status_reg <= 1'b0;
                        err_reg       <= 1'b1;
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read data is only valid during the GET cycle, so it is passed straight through then.
    assign bus.ru_byte    = ru_reading_reg ? bus.mem_data : ru_byte_reg;
    assign bus.mem_rd     = mem_rd_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.ru_status  = ru_status_reg;
    assign bus.ru_reading = ru_reading_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err            = err_reg;
    assign obj_count      = obj_count_reg;

endmodule
